// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, field positions and event encoding.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;
  localparam logic [4:0] CP0_CONFIG   = 5'd16;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_EXC_LO = 2;

  // Writable Status bits: BEV, IM, EXL, IE.
  localparam logic [31:0] STATUS_WMASK       = 32'h0040_FF03;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
  localparam logic [31:0] PRID_VALUE         = 32'h0001_8000;
  localparam logic [31:0] CONFIG_VALUE       = 32'h8000_0000;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EXC  = 2'd1,
    EV_INT  = 2'd2,
    EV_ERET = 2'd3
  } cp0_event_e;

  function automatic logic loads_badva(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_lane_arbiter.sv
// Program-order pick of the committing event (interrupt, exception, ERET) and its kill mask.
module cp0_lane_arbiter
  import cp0_pkg::*;
#(
  parameter int LANES = 2,
  parameter int IDX_W = 1
) (
  input  logic [LANES-1:0] lane_valid,
  input  logic [LANES-1:0] lane_exc,
  input  logic [LANES-1:0] lane_eret,
  input  logic             int_pending,
  input  logic             exl,
  output cp0_event_e       ev_type,
  output logic [IDX_W-1:0] ev_lane,
  output logic [LANES-1:0] kill_mask
);

  logic             int_hit_s, exc_hit_s, eret_hit_s;
  logic [IDX_W-1:0] int_lane_s, exc_lane_s, eret_lane_s;

  // Descending scan leaves the oldest matching lane; EXL masks everything but ERET
  always_comb begin
    int_hit_s   = 1'b0;
    exc_hit_s   = 1'b0;
    eret_hit_s  = 1'b0;
    int_lane_s  = '0;
    exc_lane_s  = '0;
    eret_lane_s = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_valid[i]) begin
        int_hit_s  = 1'b1;
        int_lane_s = IDX_W'(i);
      end else begin
      end
      if (lane_valid[i] && lane_exc[i] && !exl) begin
        exc_hit_s  = 1'b1;
        exc_lane_s = IDX_W'(i);
      end else begin
      end
      if (lane_valid[i] && lane_eret[i]) begin
        eret_hit_s  = 1'b1;
        eret_lane_s = IDX_W'(i);
      end else begin
      end
    end

    if (int_pending && int_hit_s) begin
      ev_type = EV_INT;
      ev_lane = int_lane_s;
    end else if (exc_hit_s) begin
      ev_type = EV_EXC;
      ev_lane = exc_lane_s;
    end else if (eret_hit_s) begin
      ev_type = EV_ERET;
      ev_lane = eret_lane_s;
    end else begin
      ev_type = EV_NONE;
      ev_lane = '0;
    end

    for (int i = 0; i < LANES; i++) begin
      case (ev_type)
        EV_INT, EV_EXC: kill_mask[i] = (i >= int'(ev_lane));
        EV_ERET:        kill_mask[i] = (i > int'(ev_lane));
        default:        kill_mask[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/cp0_multi_lane.sv
// N-lane CP0 at the commit boundary: timer, exception/interrupt/ERET arbitration, redirect.
// Optional macro CP0_CONFIG_PRID_EN adds read-only PRId(15) and Config(16).
module cp0_multi_lane
  import cp0_pkg::*;
#(
  parameter int          LANES        = 2,
  parameter int          HW_INT_W     = 6,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [HW_INT_W-1:0]   hard_int,
  input  logic [LANES-1:0]      lane_valid,
  input  logic [LANES-1:0]      lane_exc,
  input  logic [LANES*5-1:0]    lane_exccode,
  input  logic [LANES-1:0]      lane_eret,
  input  logic [LANES-1:0]      lane_bd,
  input  logic [LANES*32-1:0]   lane_pc,
  input  logic [LANES*32-1:0]   lane_badva,
  input  logic [LANES-1:0]      mtc0_en,
  input  logic [LANES*5-1:0]    mtc0_addr,
  input  logic [LANES*32-1:0]   mtc0_data,
  input  logic [LANES*5-1:0]    mfc0_addr,
  output logic [LANES*32-1:0]   mfc0_data,
  output logic [LANES-1:0]      kill_mask,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic                  exl,
  output logic                  int_pending
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [31:0]      count_r, compare_r, status_r, epc_r, badva_r, redirect_pc_r;
  logic             bd_r, ti_r, redirect_valid_r;
  logic [1:0]       ip_sw_r;
  logic [4:0]       exccode_r;
  logic [5:0]       hw_s;
  logic [7:0]       ip_s;
  logic [31:0]      cause_s, count_nxt_s, ev_pc_s, ev_badva_s;
  logic [4:0]       ev_code_s;
  logic             ev_bd_s, compare_wr_s;
  logic [LANES-1:0] wr_ok_s;
  logic [IDX_W-1:0] ev_lane_s;
  cp0_event_e       ev_s;

  assign ip_s    = {ti_r | hw_s[5], hw_s[4:0], ip_sw_r};
  assign cause_s = {bd_r, ti_r, 14'd0, ip_s, 1'b0, exccode_r, 2'b00};
  assign int_pending = status_r[STATUS_IE] & ~status_r[STATUS_EXL] &
                       (|(ip_s & status_r[STATUS_IM_LO +: 8]));
  assign exl            = status_r[STATUS_EXL];
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;

  // Map external lines onto IP[7:2], zero-filling when fewer than six exist
  always_comb begin
    hw_s = 6'd0;
    for (int i = 0; i < 6; i++) begin
      hw_s[i] = (i < HW_INT_W) ? hard_int[i] : 1'b0;
    end
  end

  cp0_lane_arbiter #(.LANES(LANES), .IDX_W(IDX_W)) u_arb (
    .lane_valid  (lane_valid),
    .lane_exc    (lane_exc),
    .lane_eret   (lane_eret),
    .int_pending (int_pending),
    .exl         (status_r[STATUS_EXL]),
    .ev_type     (ev_s),
    .ev_lane     (ev_lane_s),
    .kill_mask   (kill_mask)
  );

  // Event-lane operands, surviving mtc0 lanes and the next Count value
  always_comb begin
    ev_pc_s      = lane_pc[32*int'(ev_lane_s) +: 32];
    ev_badva_s   = lane_badva[32*int'(ev_lane_s) +: 32];
    ev_bd_s      = lane_bd[ev_lane_s];
    ev_code_s    = (ev_s == EV_INT) ? EXC_INT : lane_exccode[5*int'(ev_lane_s) +: 5];
    count_nxt_s  = count_r + 32'd1;
    compare_wr_s = 1'b0;
    wr_ok_s      = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_ok_s[i] = lane_valid[i] & mtc0_en[i] & ((ev_s == EV_NONE) | (i < int'(ev_lane_s)));
      if (wr_ok_s[i] && (mtc0_addr[5*i +: 5] == CP0_COUNT)) begin
        count_nxt_s = mtc0_data[32*i +: 32];
      end else if (wr_ok_s[i] && (mtc0_addr[5*i +: 5] == CP0_COMPARE)) begin
        compare_wr_s = 1'b1;
      end else begin
      end
    end
  end

  // Register state: lane order makes the youngest write win; event updates come last
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r          <= 32'd0;
      compare_r        <= 32'd0;
      status_r         <= RESET_STATUS;
      epc_r            <= 32'd0;
      badva_r          <= 32'd0;
      bd_r             <= 1'b0;
      ti_r             <= 1'b0;
      ip_sw_r          <= 2'b00;
      exccode_r        <= 5'd0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
    end else begin
      count_r <= count_nxt_s;
      if (compare_wr_s) begin
        ti_r <= 1'b0;
      end else if (count_nxt_s == compare_r) begin
        ti_r <= 1'b1;
      end
      for (int i = 0; i < LANES; i++) begin
        if (wr_ok_s[i]) begin
          case (mtc0_addr[5*i +: 5])
            CP0_COMPARE: compare_r <= mtc0_data[32*i +: 32];
            CP0_STATUS:  status_r  <= mtc0_data[32*i +: 32] & STATUS_WMASK;
            CP0_CAUSE:   ip_sw_r   <= mtc0_data[32*i + 8 +: 2];
            CP0_EPC:     epc_r     <= mtc0_data[32*i +: 32];
            default:     ;
          endcase
        end
      end
      redirect_valid_r <= 1'b0;
      case (ev_s)
        EV_EXC, EV_INT: begin
          status_r[STATUS_EXL] <= 1'b1;
          epc_r                <= ev_bd_s ? (ev_pc_s - 32'd4) : ev_pc_s;
          bd_r                 <= ev_bd_s;
          exccode_r            <= ev_code_s;
          if (loads_badva(ev_code_s)) begin
            badva_r <= ev_badva_s;
          end
          redirect_valid_r <= 1'b1;
          redirect_pc_r    <= EXC_VECTOR;
        end
        EV_ERET: begin
          status_r[STATUS_EXL] <= 1'b0;
          redirect_valid_r     <= 1'b1;
          redirect_pc_r        <= epc_r;
        end
        default: ;
      endcase
    end
  end

  // Per-lane mfc0 read mux over pre-edge register values
  always_comb begin
    mfc0_data = '0;
    for (int i = 0; i < LANES; i++) begin
      case (mfc0_addr[5*i +: 5])
        CP0_BADVADDR: mfc0_data[32*i +: 32] = badva_r;
        CP0_COUNT:    mfc0_data[32*i +: 32] = count_r;
        CP0_COMPARE:  mfc0_data[32*i +: 32] = compare_r;
        CP0_STATUS:   mfc0_data[32*i +: 32] = status_r;
        CP0_CAUSE:    mfc0_data[32*i +: 32] = cause_s;
        CP0_EPC:      mfc0_data[32*i +: 32] = epc_r;
`ifdef CP0_CONFIG_PRID_EN
        CP0_PRID:     mfc0_data[32*i +: 32] = PRID_VALUE;
        CP0_CONFIG:   mfc0_data[32*i +: 32] = CONFIG_VALUE;
`endif
        default:      mfc0_data[32*i +: 32] = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_multi_lane.sv
// Directed table-driven bench for cp0_multi_lane (LANES=2) plus timer-interrupt and reset sequences.
module tb_cp0_multi_lane;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hard_int;
  logic [1:0]  lane_valid, lane_exc, lane_eret, lane_bd, mtc0_en, kill_mask;
  logic [9:0]  lane_exccode, mtc0_addr, mfc0_addr;
  logic [63:0] lane_pc, lane_badva, mtc0_data, mfc0_data;
  logic        redirect_valid, exl, int_pending;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef CP0_CONFIG_PRID_EN
  localparam logic [31:0] X_PRID   = 32'h0001_8000;
  localparam logic [31:0] X_CONFIG = 32'h8000_0000;
`else
  localparam logic [31:0] X_PRID   = 32'h0;
  localparam logic [31:0] X_CONFIG = 32'h0;
`endif

  typedef struct {
    logic [1:0]  valid, exc;
    logic [4:0]  code0, code1;
    logic [1:0]  eret, bd;
    logic [31:0] pc0, pc1, bva0, bva1;
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [31:0] x_rd0, x_rd1;
    logic [1:0]  x_kill;
    logic        x_ip, x_rv;
    logic [31:0] x_rpc;
    logic        x_exl;
  } vec_t;

  vec_t tbl[15];

  cp0_multi_lane dut (
    .clk(clk), .reset(reset), .hard_int(hard_int),
    .lane_valid(lane_valid), .lane_exc(lane_exc), .lane_exccode(lane_exccode),
    .lane_eret(lane_eret), .lane_bd(lane_bd), .lane_pc(lane_pc), .lane_badva(lane_badva),
    .mtc0_en(mtc0_en), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data), .kill_mask(kill_mask),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exl(exl), .int_pending(int_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic vec_t idle(input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] x0, input logic [31:0] x1, input logic x_exl);
    vec_t v;
    v = '{2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0,
          32'h0, 32'h0, ra0, ra1, x0, x1, 2'b00, 1'b0, 1'b0, 32'h0, x_exl};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    lane_valid   = v.valid;
    lane_exc     = v.exc;
    lane_exccode = {v.code1, v.code0};
    lane_eret    = v.eret;
    lane_bd      = v.bd;
    lane_pc      = {v.pc1, v.pc0};
    lane_badva   = {v.bva1, v.bva0};
    mtc0_en      = v.wen;
    mtc0_addr    = {v.wa1, v.wa0};
    mtc0_data    = {v.wd1, v.wd0};
    mfc0_addr    = {v.ra1, v.ra0};
  endtask

  // Drive right after an edge, check combinational outputs mid-cycle, registered ones after the edge.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #4;
    check({tag, " kill_mask"}, 32'(kill_mask), 32'(v.x_kill));
    check({tag, " int_pending"}, 32'(int_pending), 32'(v.x_ip));
    check({tag, " mfc0 lane0"}, mfc0_data[31:0], v.x_rd0);
    check({tag, " mfc0 lane1"}, mfc0_data[63:32], v.x_rd1);
    @(posedge clk);
    #1;
    check({tag, " redirect_valid"}, 32'(redirect_valid), 32'(v.x_rv));
    check({tag, " exl"}, 32'(exl), 32'(v.x_exl));
    if (v.x_rv) check({tag, " redirect_pc"}, redirect_pc, v.x_rpc);
  endtask

  initial begin
    vec_t sv;
    reset    = 1'b0;
    hard_int = 6'd0;
    drive(idle(5'd12, 5'd9, 32'h0, 32'h0, 1'b0));

    tbl[0]  = '{2'b11, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01, 5'd11, 5'd0,
                32'hFFFF_0000, 32'h0, 5'd12, 5'd14, 32'h0040_0000, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0};
    tbl[1]  = '{2'b11, 2'b01, 5'd12, 5'd0, 2'b00, 2'b00, 32'h100, 32'h104, 32'hDEAD, 32'h0, 2'b00, 5'd0, 5'd0,
                32'h0, 32'h0, 5'd11, 5'd13, 32'hFFFF_0000, 32'h0, 2'b11, 1'b0, 1'b1, 32'hBFC0_0380, 1'b1};
    tbl[2]  = idle(5'd14, 5'd13, 32'h100, 32'h30, 1'b1);
    tbl[3]  = '{2'b11, 2'b10, 5'd0, 5'd8, 2'b00, 2'b00, 32'h120, 32'h124, 32'h0, 32'h0, 2'b01, 5'd14, 5'd0,
                32'h400, 32'h0, 5'd12, 5'd8, 32'h0040_0002, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1};
    tbl[4]  = '{2'b11, 2'b00, 5'd0, 5'd0, 2'b01, 2'b00, 32'h400, 32'h404, 32'h0, 32'h0, 2'b10, 5'd0, 5'd12,
                32'h0, 32'hFFFF_FFFF, 5'd14, 5'd12, 32'h400, 32'h0040_0002, 2'b10, 1'b0, 1'b1, 32'h400, 1'b0};
    tbl[5]  = idle(5'd12, 5'd14, 32'h0040_0000, 32'h400, 1'b0);
    tbl[6]  = '{2'b11, 2'b10, 5'd0, 5'd4, 2'b00, 2'b10, 32'h200, 32'h204, 32'h0, 32'h3, 2'b01, 5'd11, 5'd0,
                32'h5, 32'h0, 5'd8, 5'd13, 32'h0, 32'h30, 2'b10, 1'b0, 1'b1, 32'hBFC0_0380, 1'b1};
    tbl[7]  = idle(5'd14, 5'd13, 32'h200, 32'h8000_0010, 1'b1);
    tbl[8]  = idle(5'd8, 5'd11, 32'h3, 32'h5, 1'b1);
    tbl[9]  = '{2'b01, 2'b00, 5'd0, 5'd0, 2'b01, 2'b00, 32'h208, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0,
                32'h0, 32'h0, 5'd12, 5'd15, 32'h0040_0002, X_PRID, 2'b10, 1'b0, 1'b1, 32'h200, 1'b0};
    tbl[10] = '{2'b11, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 5'd12, 5'd12,
                32'h1, 32'h8000, 5'd12, 5'd16, 32'h0040_0000, X_CONFIG, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0};
    tbl[11] = idle(5'd12, 5'd14, 32'h8000, 32'h200, 1'b0);
    tbl[12] = '{2'b01, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01, 5'd9, 5'd0,
                32'hFFFF_FFFF, 32'h0, 5'd12, 5'd13, 32'h8000, 32'h8000_0010, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0};
    tbl[13] = idle(5'd9, 5'd11, 32'hFFFF_FFFF, 32'h5, 1'b0);
    tbl[14] = idle(5'd9, 5'd8, 32'h0, 32'h3, 1'b0);

    // Reset state
    #15;
    check("reset redirect_valid", 32'(redirect_valid), 32'h0);
    check("reset redirect_pc", redirect_pc, 32'h0);
    check("reset exl", 32'(exl), 32'h0);
    check("reset kill_mask", 32'(kill_mask), 32'h0);
    check("reset status", mfc0_data[31:0], 32'h0040_0000);
    check("reset count", mfc0_data[63:32], 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Timer interrupt: enable IE+IM7, then Count=8 / Compare=10 in one cycle
    sv = '{2'b01, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 32'h300, 32'h0, 32'h0, 32'h0, 2'b01, 5'd12, 5'd0,
           32'h0000_8001, 32'h0, 5'd9, 5'd13, 32'h1, 32'h8000_0010, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0};
    apply(sv, "tmr_a");
    sv = '{2'b11, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 5'd9, 5'd11,
           32'd8, 32'd10, 5'd12, 5'd9, 32'h0000_8001, 32'h2, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0};
    apply(sv, "tmr_b");
    apply(idle(5'd9, 5'd13, 32'd8, 32'h8000_0010, 1'b0), "tmr_c");
    apply(idle(5'd9, 5'd13, 32'd9, 32'h8000_0010, 1'b0), "tmr_d");
    sv = '{2'b10, 2'b10, 5'd0, 5'd10, 2'b00, 2'b00, 32'h0, 32'h300, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0,
           32'h0, 32'h0, 5'd9, 5'd13, 32'd10, 32'hC000_8010, 2'b10, 1'b1, 1'b1, 32'hBFC0_0380, 1'b1};
    apply(sv, "tmr_int");
    apply(idle(5'd14, 5'd13, 32'h300, 32'h4000_8000, 1'b1), "tmr_post");

    // ERET then reset while the redirect pulse is high
    sv = '{2'b01, 2'b00, 5'd0, 5'd0, 2'b01, 2'b00, 32'h500, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0,
           32'h0, 32'h0, 5'd12, 5'd14, 32'h0000_8003, 32'h300, 2'b10, 1'b0, 1'b1, 32'h300, 1'b0};
    apply(sv, "eret_rst");
    reset = 1'b0;
    #1;
    drive(idle(5'd12, 5'd13, 32'h0, 32'h0, 1'b0));
    #1;
    check("midreset redirect_valid", 32'(redirect_valid), 32'h0);
    check("midreset redirect_pc", redirect_pc, 32'h0);
    check("midreset exl", 32'(exl), 32'h0);
    check("midreset kill_mask", 32'(kill_mask), 32'h0);
    check("midreset int_pending", 32'(int_pending), 32'h0);
    check("midreset status", mfc0_data[31:0], 32'h0040_0000);
    check("midreset cause", mfc0_data[63:32], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cp0_multi_lane.md
Name: cp0_multi_lane

Overview:
- Parametrised successor of the dual-issue CP0 for an N-lane in-order MIPS core.
- Keeps Count/Compare/Status/Cause/EPC/BadVAddr.
- Arbitrates exceptions, interrupts and ERET across LANES commit slots in program order (lane 0 oldest).
- Issues a registered pipeline redirect and a combinational per-lane kill mask. Sits at the MEM/WB commit boundary.

Parameters:
- LANES, 2, number of commit lanes (1..4)
- HW_INT_W, 6, external hardware interrupt lines
- EXC_VECTOR, 32'hBFC0_0380, general exception entry PC
- RESET_STATUS, 32'h0040_0000, Status reset value (BEV=1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- hard_int  in  HW_INT_W  level-sensitive external interrupts, into Cause.IP[7:2]
- lane_valid  in  LANES  instruction in lane commits this cycle
- lane_exc  in  LANES  lane carries a synchronous exception
- lane_exccode  in  LANES*5  ExcCode per lane
- lane_eret  in  LANES  lane is ERET
- lane_bd  in  LANES  lane is in a delay slot
- lane_pc  in  LANES*32  lane PC
- lane_badva  in  LANES*32  faulting address per lane
- mtc0_en  in  LANES  lane writes CP0
- mtc0_addr  in  LANES*5  write register number
- mtc0_data  in  LANES*32  write data
- mfc0_addr  in  LANES*5  read register number
- mfc0_data  out  LANES*32  combinational read data
- kill_mask  out  LANES  combinational; lanes squashed this cycle
- redirect_valid  out  1  registered; fetch redirect
- redirect_pc  out  32  registered redirect target
- exl  out  1  Status.EXL
- int_pending  out  1  combinational; an enabled interrupt is pending

Behaviour:
Registers and fields:
- BadVAddr(8), Count(9), Compare(11), Status(12: IM[15:8], EXL[1], IE[0]), Cause(13: BD[31], TI[30], IP[15:8], ExcCode[6:2]), EPC(14).
- Unimplemented fields read 0.
- Reset values: Status=RESET_STATUS; all other registers 0; redirect_valid=0; redirect_pc=0.

Count and timer:
- Count increments every cycle; wraps 32'hFFFF_FFFF to 0.
- Count==Compare sets TI=1 and IP[7]=1. Both hold until Compare is written, which clears them.

Interrupt:
- int_pending = IE & ~EXL & |(Cause.IP & Status.IM).
- Taken only when at least one lane_valid; it attaches to the lowest valid lane.

Event selection each cycle, first match in this order:
1. Interrupt: victim = lowest valid lane, ExcCode=0.
2. Lowest lane with lane_valid & lane_exc.
3. Lowest lane with lane_valid & lane_eret.
Any event is ignored while EXL=1, except ERET.

On exception or interrupt at lane k:
- EPC = lane_bd[k] ? pc-4 : pc; BD=lane_bd[k]; ExcCode set; EXL=1.
- BadVAddr loaded for ExcCode 4/5 only.
- Next cycle: redirect_valid=1, redirect_pc=EXC_VECTOR.
- kill_mask = lanes k..LANES-1.

On ERET at lane k:
- EXL=0.
- Next cycle: redirect_valid=1, redirect_pc=EPC value before this edge.
- kill_mask = lanes k+1..LANES-1.

Write rules:
- mtc0 applies only for lanes older than the event lane.
- With no event, all valid lanes' writes apply. Multiple writes to one register: highest surviving lane wins.
- An mtc0 to Count overrides the increment.
- Event updates of EXL/EPC/Cause override same-cycle mtc0.

Read and pulse rules:
- mfc0 returns pre-edge register values; no bypass.
- redirect_valid is a 1-cycle pulse.

Reset: asserting reset mid-operation clears everything immediately, including a pending redirect.

Optional Feature:
- Macro CP0_CONFIG_PRID_EN.
- Defined: PRId(15)=32'h0001_8000 and Config(16)=32'h8000_0000 read-only; mtc0 to them ignored.
- Undefined: reads of 15/16 return 0.

Decomposition:
- Package cp0_pkg: register numbers, ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12), field bit positions, EXC_VECTOR default.
- Sub-module cp0_lane_arbiter: combinational priority pick returning event type, lane index and kill_mask.

Test Plan:
- lane0 exc OV, pc=0x100, bd=0 -> EPC=0x100, ExcCode=12, EXL=1, kill_mask=2'b11, next cycle redirect_pc=0xBFC00380.
- lane1 ADEL, bd=1, pc=0x204, badva=0x3; lane0 mtc0 Compare=5 -> EPC=0x200, BD=1, BadVAddr=0x3, Compare=5, kill_mask=2'b10.
- Compare=10, Count=8, IE=1, IM[7]=1, EXL=0 -> TI=1 two cycles later; next valid lane takes interrupt, ExcCode=0.
- EXL=1, EPC=0x400, lane0 ERET -> EXL=0, redirect_pc=0x400, kill_mask=2'b10.
- Both lanes mtc0 Status, no event -> lane1 value stored.
- Assert reset mid-redirect -> redirect_valid=0 immediately, Status=0x00400000.
